// File: rtl/fetch_queue_6502.sv
// fetch_queue_6502: prefetching byte queue that assembles 1-3 byte 6502 instructions for decode.
// Optional RESET_VECTOR_EN: take the start PC from the reset vector at 0xFFFC/0xFFFD instead of RESET_PC.
module fetch_queue_6502 #(
  parameter int                ADDR_W   = 16,
  parameter int                QDEPTH   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    fetch_req,
  output logic [ADDR_W-1:0]       fetch_addr,
  input  logic                    fetch_gnt,
  input  logic [7:0]              fetch_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [7:0]              instr_opcode,
  output logic [7:0]              instr_op1,
  output logic [7:0]              instr_op2,
  output logic [1:0]              instr_len,
  output logic [ADDR_W-1:0]       instr_pc,
  output logic [$clog2(QDEPTH):0] q_level
);

  localparam int                PTR_W     = $clog2(QDEPTH);
  localparam int                LVL_W     = PTR_W + 1;
  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(QDEPTH);
  localparam logic [ADDR_W-1:0] VEC_ADDR  = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } state_t;

  logic [7:0]        queue_mem [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] head_pc_r;
  logic              inflight_r;
  logic [7:0]        vec_lo_r;
  state_t            state_r;

  logic [7:0] head_byte_s;
  logic [7:0] byte1_s;
  logic [7:0] byte2_s;
  logic [1:0] head_len_s;
  logic [1:0] pop_len_s;
  logic       run_s;
  logic       redirect_s;
  logic       push_s;
  logic       grant_s;

  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    if (op[3:0] == 4'h8 || op[3:0] == 4'hA || op == 8'h40 || op == 8'h60) begin
      len = 2'd1;
    end else if (op[3:2] == 2'b11 || op == 8'h20 || op[4:0] == 5'b11001) begin
      len = 2'd3;
    end else begin
      len = 2'd2;
    end
    return len;
  endfunction

  assign fetch_addr = fetch_pc_r;
  assign q_level    = level_r;

  // Head decode, decode-side handshake and bus request.
  always_comb begin
    head_byte_s = queue_mem[rd_ptr_r];
    byte1_s     = queue_mem[rd_ptr_r + PTR_W'(1)];
    byte2_s     = queue_mem[rd_ptr_r + PTR_W'(2)];
    head_len_s  = decode_len(head_byte_s);
    run_s       = (state_r == RUN);
    redirect_s  = run_s && redirect_valid;
    instr_valid = run_s && !redirect_valid && !rst && (level_r >= LVL_W'(head_len_s));
    if (instr_valid) begin
      instr_opcode = head_byte_s;
      instr_op1    = (head_len_s >= 2'd2) ? byte1_s : 8'h00;
      instr_op2    = (head_len_s == 2'd3) ? byte2_s : 8'h00;
      instr_len    = head_len_s;
      instr_pc     = head_pc_r;
    end else begin
      instr_opcode = 8'h00;
      instr_op1    = 8'h00;
      instr_op2    = 8'h00;
      instr_len    = 2'd0;
      instr_pc     = {ADDR_W{1'b0}};
    end
    pop_len_s = (instr_valid && instr_ready) ? head_len_s : 2'd0;
    push_s    = run_s && inflight_r && !redirect_valid;
    // Vector fetches are strictly one at a time; the queue is not involved.
    if (rst) begin
      fetch_req = 1'b0;
    end else if (run_s) begin
      fetch_req = !redirect_valid && ((level_r + LVL_W'(inflight_r)) < DEPTH_LVL);
    end else begin
      fetch_req = !inflight_r;
    end
    grant_s = fetch_req && fetch_gnt;
  end

  // Queue, pointers, PCs and the reset-vector sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        queue_mem[i] <= 8'h00;
      end
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      inflight_r <= 1'b0;
      vec_lo_r   <= 8'h00;
`ifdef RESET_VECTOR_EN
      state_r    <= VEC_LO;
      fetch_pc_r <= VEC_ADDR;
      head_pc_r  <= VEC_ADDR;
`else
      state_r    <= RUN;
      fetch_pc_r <= RESET_PC;
      head_pc_r  <= RESET_PC;
`endif
    end else if (redirect_s) begin
      // Clearing inflight drops the returning byte: it is never pushed.
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      inflight_r <= 1'b0;
      fetch_pc_r <= redirect_pc;
      head_pc_r  <= redirect_pc;
    end else begin
      inflight_r <= grant_s;
      if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
      end
      case (state_r)
        VEC_LO: begin
          if (inflight_r) begin
            vec_lo_r <= fetch_data;
            state_r  <= VEC_HI;
          end
        end
        VEC_HI: begin
          if (inflight_r) begin
            fetch_pc_r <= ADDR_W'({fetch_data, vec_lo_r});
            head_pc_r  <= ADDR_W'({fetch_data, vec_lo_r});
            state_r    <= RUN;
          end
        end
        RUN: begin
          if (push_s) begin
            queue_mem[wr_ptr_r] <= fetch_data;
            wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
          end
          rd_ptr_r  <= rd_ptr_r + PTR_W'(pop_len_s);
          head_pc_r <= head_pc_r + ADDR_W'(pop_len_s);
          level_r   <= level_r + LVL_W'(push_s) - LVL_W'(pop_len_s);
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue_6502.sv
// Directed bench for fetch_queue_6502: bus responder with a fixed memory image, an
// instruction monitor, a table of expected instructions and hand-timed corner sequences.
module tb_fetch_queue_6502;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  op;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic [7:0]  fetch_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_op1;
  logic [7:0]  instr_op2;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic [3:0]  q_level;

  int total = 0;
  int bad   = 0;

  instr_t exp_tab [8];
  instr_t cap_q [$];
  instr_t fields;

  fetch_queue_6502 #(
    .ADDR_W  (16),
    .QDEPTH  (8),
    .RESET_PC(16'h8000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_gnt     (fetch_gnt),
    .fetch_data    (fetch_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_op1     (instr_op1),
    .instr_op2     (instr_op2),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc),
    .q_level       (q_level)
  );

  always #5 clk = ~clk;

  assign fields = {instr_pc, instr_opcode, instr_op1, instr_op2, instr_len};

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h8000: mem_byte = 8'hA9;
      16'h8001: mem_byte = 8'h05;
      16'h8002: mem_byte = 8'h8D;
      16'h8003: mem_byte = 8'h00;
      16'h8004: mem_byte = 8'h02;
      16'hC000: mem_byte = 8'hA2;
      16'hC001: mem_byte = 8'h7F;
      16'hFFFE: mem_byte = 8'h4C;
      16'hFFFF: mem_byte = 8'h34;
      16'h0000: mem_byte = 8'h12;
      16'hFFFC: mem_byte = 8'h00;
      16'hFFFD: mem_byte = 8'hC0;
      default:  mem_byte = 8'hEA;
    endcase
  endfunction

  // Bus responder: data for a gnt seen in one cycle is driven during the next.
  initial begin
    logic        pend;
    logic [15:0] paddr;
    pend       = 1'b0;
    paddr      = 16'h0000;
    fetch_data = 8'h00;
    forever begin
      @(negedge clk);
      fetch_data = pend ? mem_byte(paddr) : 8'h00;
      pend       = fetch_req && fetch_gnt;
      paddr      = fetch_addr;
    end
  end

  // Instruction monitor: record every accepted instruction.
  initial begin
    forever begin
      @(negedge clk);
      if (instr_valid && instr_ready) cap_q.push_back(fields);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stream(input string name, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      total++;
      if (i >= cap_q.size()) begin
        bad++;
        $display("FAIL %s[%0d]: got nothing expected %0h", name, i, exp_tab[first+i]);
      end else if (cap_q[i] !== exp_tab[first+i]) begin
        bad++;
        $display("FAIL %s[%0d]: got %0h expected %0h", name, i, cap_q[i], exp_tab[first+i]);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) next_cycle();
  endtask

  initial begin
    exp_tab[0] = '{16'h8000, 8'hA9, 8'h05, 8'h00, 2'd2};
    exp_tab[1] = '{16'h8002, 8'h8D, 8'h00, 8'h02, 2'd3};
    exp_tab[2] = '{16'h8005, 8'hEA, 8'h00, 8'h00, 2'd1};
    exp_tab[3] = '{16'h8006, 8'hEA, 8'h00, 8'h00, 2'd1};
    exp_tab[4] = '{16'hC000, 8'hA2, 8'h7F, 8'h00, 2'd2};
    exp_tab[5] = '{16'hC002, 8'hEA, 8'h00, 8'h00, 2'd1};
    exp_tab[6] = '{16'hFFFE, 8'h4C, 8'h34, 8'h12, 2'd3};
    exp_tab[7] = '{16'h0001, 8'hEA, 8'h00, 8'h00, 2'd1};

    rst = 1'b1; fetch_gnt = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    next_cycle(); next_cycle();
    @(negedge clk);
    chk("rst_req", 64'(fetch_req), 64'd0);
    chk("rst_level", 64'(q_level), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_fields", 64'(fields), 64'd0);
`ifdef RESET_VECTOR_EN
    chk("rst_addr", 64'(fetch_addr), 64'hFFFC);
`else
    chk("rst_addr", 64'(fetch_addr), 64'h8000);
`endif
    next_cycle(); rst = 1'b0;

`ifdef RESET_VECTOR_EN
    @(negedge clk); chk("vec_addr_lo", 64'(fetch_addr), 64'hFFFC); chk("vec_req_lo", 64'(fetch_req), 64'd1);
    next_cycle(); @(negedge clk); chk("vec_req_wait", 64'(fetch_req), 64'd0);
    next_cycle(); @(negedge clk); chk("vec_addr_hi", 64'(fetch_addr), 64'hFFFD);
    next_cycle();
    next_cycle(); @(negedge clk); chk("vec_addr_run", 64'(fetch_addr), 64'hC000);
    next_cycle(); next_cycle(); next_cycle(); @(negedge clk);
    chk("vec_first_valid", 64'(instr_valid), 64'd1);
    chk("vec_first_pc", 64'(instr_pc), 64'hC000);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 16'h8000; cap_q.delete();
    next_cycle(); redirect_valid = 1'b0;
`endif

    // Stream from 0x8000: first byte visible two cycles after its grant.
    @(negedge clk); chk("c0_addr", 64'(fetch_addr), 64'h8000); chk("c0_req", 64'(fetch_req), 64'd1);
    chk("c0_level", 64'(q_level), 64'd0);
    next_cycle(); @(negedge clk); chk("c1_addr", 64'(fetch_addr), 64'h8001); chk("c1_level", 64'(q_level), 64'd0);
    next_cycle(); @(negedge clk); chk("c2_level", 64'(q_level), 64'd1); chk("c2_partial", 64'(instr_valid), 64'd0);
    run(20); @(negedge clk);
    check_stream("stream8000", 0, 4);

    // Decode stalled: fill to QDEPTH, request stops, head holds.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 16'h8000; instr_ready = 1'b0;
    @(negedge clk); chk("redir_req", 64'(fetch_req), 64'd0); chk("redir_valid", 64'(instr_valid), 64'd0);
    cap_q.delete();
    next_cycle(); redirect_valid = 1'b0;
    run(7); @(negedge clk); chk("fill_level6", 64'(q_level), 64'd6); chk("fill_req6", 64'(fetch_req), 64'd1);
    next_cycle(); @(negedge clk); chk("fill_level7", 64'(q_level), 64'd7); chk("fill_req7", 64'(fetch_req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); @(negedge clk);
      chk("full_level", 64'(q_level), 64'd8);
      chk("full_req", 64'(fetch_req), 64'd0);
      chk("hold_fields", 64'(fields), 64'(exp_tab[0]));
    end
    next_cycle(); instr_ready = 1'b1;
    next_cycle(); instr_ready = 1'b0;
    @(negedge clk);
    chk("pop_level", 64'(q_level), 64'd6);
    chk("pop_next_head", 64'(fields), 64'(exp_tab[1]));
    chk("pop_count", 64'(cap_q.size()), 64'd1);
    check_stream("pop_one", 0, 1);

    // Redirect while a byte is in flight: that byte must never reach the queue.
    next_cycle(); fetch_gnt = 1'b0; instr_ready = 1'b1;
    run(3); fetch_gnt = 1'b1;
    @(negedge clk); chk("inflight_req", 64'(fetch_req), 64'd1);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 16'hC000;
    @(negedge clk); chk("kill_req", 64'(fetch_req), 64'd0); chk("kill_valid", 64'(instr_valid), 64'd0);
    cap_q.delete();
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk); chk("kill_addr", 64'(fetch_addr), 64'hC000); chk("kill_level", 64'(q_level), 64'd0);
    run(10); @(negedge clk);
    check_stream("streamC000", 4, 2);

    // Address wrap across 0xFFFF.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk); cap_q.delete();
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk); chk("wrap_addr0", 64'(fetch_addr), 64'hFFFE);
    next_cycle(); @(negedge clk); chk("wrap_addr1", 64'(fetch_addr), 64'hFFFF);
    next_cycle(); @(negedge clk); chk("wrap_addr2", 64'(fetch_addr), 64'h0000);
    run(10); @(negedge clk);
    check_stream("streamwrap", 6, 2);

    // Grant withheld for five cycles mid-stream.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 16'h8000;
    @(negedge clk); cap_q.delete();
    next_cycle(); redirect_valid = 1'b0;
    run(4); fetch_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_addr", 64'(fetch_addr), 64'h8004);
      chk("stall_req", 64'(fetch_req), 64'd1);
      next_cycle();
    end
    fetch_gnt = 1'b1;
    @(negedge clk); chk("stall_level", 64'(q_level), 64'd2); chk("stall_valid", 64'(instr_valid), 64'd0);
    run(12); @(negedge clk);
    check_stream("streamstall", 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
